ber_error_path: RTL and testbench
=================================

Name: ber_error_path

Overview:
- Datapath slice of the bit-error-ratio tester, sitting between the pattern generator and the test controller.
- Selects the test word, either the 13-bit PRBS word or a word assembled from the serial normal input.
- Injects a controlled single-bit error into the selected word and compares the clean and corrupted words.
- Reports the per-bit error vector, the per-word error count and a running error total. All outputs are registered.

Parameters:
- WIDTH, 13: word width of test pattern and all word outputs; supported range 2..16.
- TOTAL_W, 16: width of the running error-total accumulator.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- sel  input  1  1 = use test_pattern, 0 = use the normal-input shift word.
- test_pattern  input  WIDTH  parallel PRBS word from the transmit block.
- normal_input  input  1  serial user data bit, sampled every clock.
- inject_en  input  1  1 = flip one bit of the selected word this cycle.
- inject_pos  input  4  index of the bit to flip (0 = LSB).
- total_clr  input  1  synchronous clear of total_error.
- original  output  WIDTH  registered selected (clean) word.
- corrupted  output  WIDTH  registered word after error injection.
- error  output  WIDTH  registered per-bit mismatch, original XOR corrupted.
- sum_error  output  5  registered population count of error.
- total_error  output  TOTAL_W  saturating running sum of sum_error.

Behaviour:
- Reset: reset low forces the shift word, original, corrupted, error, sum_error and total_error to 0 immediately, independent of clock. Mid-operation reset discards in-flight data. The first valid output appears one edge after reset is released.
- Normal-input shift word:
  - nsw_next = {nsw[WIDTH-2:0], normal_input}; nsw <= nsw_next on every edge, regardless of sel.
  - The newest bit lands in the LSB and the oldest bit is dropped from the MSB.
- Mux (combinational): sel_word = sel ? test_pattern : nsw_next.
- Injection mask (combinational):
  - mask = 1 << inject_pos when inject_en = 1 and inject_pos < WIDTH; otherwise mask = 0.
  - An out-of-range inject_pos is silently ignored and no error is flagged.
- Register stage, one edge, latency 1 from inputs to every word output:
  - original <= sel_word.
  - corrupted <= sel_word XOR mask.
  - error <= sel_word XOR (sel_word XOR mask), which equals mask. It must be computed as a true comparison of the two words, not wired from the mask.
  - sum_error <= popcount of that compare result, 0..WIDTH. With single-bit injection it is only ever 0 or 1.
- Running total (total_error):
  - Updates on the same edge using the combinational popcount.
  - total_clr = 1: total_error <= 0. Clear has priority, and the popcount of that cycle is discarded.
  - Otherwise total_error <= min(total_error + popcount, 2^TOTAL_W - 1). It saturates, never wraps; at 0xFFFF it holds.
- No handshake: every clock edge processes one word.
- When sel changes, the new source is reflected in original on the next edge. No pipeline bubble is needed.

Test Plan:
- Reset, then sel=1, test_pattern=13'h1ABC, inject_en=0, one edge -> original=corrupted=13'h1ABC, error=0, sum_error=0, total_error=0.
- sel=1, test_pattern=13'h1ABC, inject_en=1:
  - inject_pos=0 -> corrupted=13'h1ABD, error=13'h0001, sum_error=1, total_error=1.
  - next edge with inject_pos=12 -> corrupted=13'h0ABC, error=13'h1000, total_error=2.
- inject_en=1, inject_pos=13 or 15 -> corrupted=original, error=0, sum_error=0, total_error unchanged.
- sel=0 after reset, normal_input=1,0,1 on three edges -> original = 13'h0001, 13'h0002, 13'h0005. After 13 consecutive 1s -> 13'h1FFF; a further 0 -> 13'h1FFE.
- Total handling:
  - Preload total to 0xFFFE via 0xFFFE injected edges, then inject on 3 more edges -> total_error = 0xFFFF and holds.
  - total_clr=1 with inject active -> total_error=0 on that edge.
- Assert reset low between edges during active injection -> all outputs 0 at once. Release with inject_en=0 -> after one edge, outputs track the inputs with error=0.

Source files
------------

// File: rtl/ber_error_path.sv
// Error-path slice of the BER tester: source select, single-bit error injection,
// clean/corrupted compare and a saturating running error total.
module ber_error_path #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned TOTAL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sel,
    input  logic [WIDTH-1:0]   test_pattern,
    input  logic               normal_input,
    input  logic               inject_en,
    input  logic [3:0]         inject_pos,
    input  logic               total_clr,
    output logic [WIDTH-1:0]   original,
    output logic [WIDTH-1:0]   corrupted,
    output logic [WIDTH-1:0]   error,
    output logic [4:0]         sum_error,
    output logic [TOTAL_W-1:0] total_error
);

    logic [WIDTH-1:0]   nsw_q;
    logic [WIDTH-1:0]   nsw_d;
    logic [WIDTH-1:0]   sel_word;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   corr_word;
    logic [WIDTH-1:0]   cmp_word;
    logic [4:0]         pop;
    logic [TOTAL_W:0]   total_sum;
    logic [TOTAL_W-1:0] total_d;

    always_comb begin
        nsw_d     = {nsw_q[WIDTH-2:0], normal_input};
        sel_word  = sel ? test_pattern : nsw_d;
        // Out-of-range positions match no bit, so the mask stays zero.
        mask      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = inject_en && (inject_pos == 4'(i));
        end
        corr_word = sel_word ^ mask;
        cmp_word  = sel_word ^ corr_word;
        pop       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + 5'(cmp_word[i]);
        end
    end

    always_comb begin
        total_sum = {1'b0, total_error} + (TOTAL_W + 1)'(pop);
        total_d   = total_error;
        if (total_clr) begin
            total_d = '0;
        end else if (total_sum[TOTAL_W]) begin
            total_d = '1;
        end else begin
            total_d = total_sum[TOTAL_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nsw_q       <= '0;
            original    <= '0;
            corrupted   <= '0;
            error       <= '0;
            sum_error   <= '0;
            total_error <= '0;
        end else begin
            nsw_q       <= nsw_d;
            original    <= sel_word;
            corrupted   <= corr_word;
            error       <= cmp_word;
            sum_error   <= pop;
            total_error <= total_d;
        end
    end

endmodule

// File: tb/tb_ber_error_path.sv
// Directed self-checking bench for ber_error_path with hand-computed expectations.
module tb_ber_error_path;

    localparam int unsigned WIDTH   = 13;
    localparam int unsigned TOTAL_W = 16;

    logic               clock;
    logic               reset;
    logic               sel;
    logic [WIDTH-1:0]   test_pattern;
    logic               normal_input;
    logic               inject_en;
    logic [3:0]         inject_pos;
    logic               total_clr;
    logic [WIDTH-1:0]   original;
    logic [WIDTH-1:0]   corrupted;
    logic [WIDTH-1:0]   error;
    logic [4:0]         sum_error;
    logic [TOTAL_W-1:0] total_error;

    int checks = 0;
    int errors = 0;

    ber_error_path #(
        .WIDTH   (WIDTH),
        .TOTAL_W (TOTAL_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sel          (sel),
        .test_pattern (test_pattern),
        .normal_input (normal_input),
        .inject_en    (inject_en),
        .inject_pos   (inject_pos),
        .total_clr    (total_clr),
        .original     (original),
        .corrupted    (corrupted),
        .error        (error),
        .sum_error    (sum_error),
        .total_error  (total_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] orig_exp,
                              input logic [31:0] corr_exp, input logic [31:0] err_exp,
                              input logic [31:0] sum_exp, input logic [31:0] tot_exp);
        check({tag, ".original"},    32'(original),    orig_exp);
        check({tag, ".corrupted"},   32'(corrupted),   corr_exp);
        check({tag, ".error"},       32'(error),       err_exp);
        check({tag, ".sum_error"},   32'(sum_error),   sum_exp);
        check({tag, ".total_error"}, 32'(total_error), tot_exp);
    endtask

    initial begin
        logic [3:0]  bits3 [3];
        logic [31:0] exp3  [3];
        bits3 = '{4'd1, 4'd0, 4'd1};
        exp3  = '{32'h0001, 32'h0002, 32'h0005};

        reset        = 1'b0;
        sel          = 1'b0;
        test_pattern = '0;
        normal_input = 1'b0;
        inject_en    = 1'b0;
        inject_pos   = '0;
        total_clr    = 1'b0;
        #2;
        check_word("reset", 0, 0, 0, 0, 0);

        sel          = 1'b1;
        test_pattern = 13'h1ABC;
        #1 reset     = 1'b1;
        step();
        check_word("clean", 32'h1ABC, 32'h1ABC, 0, 0, 0);

        inject_en  = 1'b1;
        inject_pos = 4'd0;
        step();
        check_word("inj0", 32'h1ABC, 32'h1ABD, 32'h0001, 1, 1);

        inject_pos = 4'd12;
        step();
        check_word("inj12", 32'h1ABC, 32'h0ABC, 32'h1000, 1, 2);

        inject_pos = 4'd13;
        step();
        check_word("inj13", 32'h1ABC, 32'h1ABC, 0, 0, 2);

        inject_pos = 4'd15;
        step();
        check_word("inj15", 32'h1ABC, 32'h1ABC, 0, 0, 2);

        // Serial path: shift word has only seen zeros so far.
        inject_en = 1'b0;
        sel       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            normal_input = bits3[i][0];
            step();
            check($sformatf("nsw%0d", i), 32'(original), exp3[i]);
        end
        normal_input = 1'b1;
        for (int i = 0; i < 13; i++) step();
        check("nsw_ones", 32'(original), 32'h1FFF);
        normal_input = 1'b0;
        step();
        check_word("nsw_zero", 32'h1FFE, 32'h1FFE, 0, 0, 2);

        sel          = 1'b1;
        test_pattern = 13'h0555;
        step();
        check("sel_switch", 32'(original), 32'h0555);

        // Saturation: clear, preload to 0xFFFE, then three more injected edges.
        inject_en  = 1'b1;
        inject_pos = 4'd3;
        total_clr  = 1'b1;
        step();
        check("clr_pre", 32'(total_error), 0);
        total_clr = 1'b0;
        for (int i = 0; i < 16'hFFFE; i++) step();
        check("preload", 32'(total_error), 32'hFFFE);
        check("preload.corrupted", 32'(corrupted), 32'h055D);
        step();
        check("sat1", 32'(total_error), 32'hFFFF);
        step();
        check("sat2", 32'(total_error), 32'hFFFF);
        step();
        check("sat3", 32'(total_error), 32'hFFFF);

        total_clr = 1'b1;
        step();
        check("clr", 32'(total_error), 0);
        check("clr.sum_error", 32'(sum_error), 1);
        total_clr = 1'b0;
        step();
        check("after_clr", 32'(total_error), 1);

        // Asynchronous reset mid-injection.
        #2 reset = 1'b0;
        #1;
        check_word("async_rst", 0, 0, 0, 0, 0);
        inject_en    = 1'b0;
        test_pattern = 13'h1234;
        normal_input = 1'b0;
        #1 reset     = 1'b1;
        step();
        check_word("post_rst", 32'h1234, 32'h1234, 0, 0, 0);
        sel          = 1'b0;
        normal_input = 1'b1;
        step();
        check("post_rst_nsw", 32'(original), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
